// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage: req/gnt request handshake plus an
// rvalid response channel that carries read data (or a store ack).
interface mem_stage_if;
    logic        DMem_req;
    logic        DMem_we;
    logic [31:0] DMem_addr;
    logic [3:0]  DMem_be;
    logic [31:0] DMem_wdata;
    logic        DMem_gnt;
    logic        DMem_rvalid;
    logic [31:0] DMem_rdata;

    modport master (
        output DMem_req, DMem_we, DMem_addr, DMem_be, DMem_wdata,
        input  DMem_gnt, DMem_rvalid, DMem_rdata
    );

    modport slave (
        input  DMem_req, DMem_we, DMem_addr, DMem_be, DMem_wdata,
        output DMem_gnt, DMem_rvalid, DMem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Issues sub-word/word loads and stores on a
// req/gnt/rvalid bus, stalls the front of the pipe while an access is in
// flight, aborts hung accesses after TIMEOUT_CYCLES, and registers results
// into the MEM/WB register.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        EX_Mem_wr_en,
    input  logic        EX_Mem_rd_en,
    input  logic [2:0]  EX_Mem_op,
    input  logic [31:0] EX_ALU_result,
    input  logic [31:0] EX_Rs2_data,
    input  logic        EX_MemToReg,
    input  logic        EX_RegFile_wr_en,
    input  logic [4:0]  EX_Rd_addr,
    output logic        MEM_Stall,
    mem_stage_if.master dmem,
    output logic        MEM_RegFile_wr_en,
    output logic [4:0]  MEM_Rd_addr,
    output logic        MEM_MemToReg,
    output logic [31:0] MEM_ALU_result,
    output logic [31:0] MEM_Read_data,
    output logic        MEM_Misaligned,
    output logic        MEM_Bus_error
);

    // Last counter value at which the access may still complete normally.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    state_e      state_q;
    logic [7:0]  tmo_cnt_q;

    logic        access_s;
    logic        is_load_s;
    logic        misaligned_s;
    logic        issue_s;
    logic        done_s;
    logic        timeout_s;
    logic        stall_s;
    logic [1:0]  size_s;
    logic [1:0]  off_s;

    logic        wb_wr_en_q,  wb_wr_en_d;
    logic [4:0]  wb_rd_q,     wb_rd_d;
    logic        wb_m2r_q,    wb_m2r_d;
    logic [31:0] wb_alu_q,    wb_alu_d;
    logic [31:0] wb_rdata_q,  wb_rdata_d;
    logic        wb_mis_q,    wb_mis_d;
    logic        wb_berr_q,   wb_berr_d;

    // Access size from funct3[1:0]: 00 byte, 01 half, anything else word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   calc_be = 4'b0001 << off;
            2'b01:   calc_be = 4'b0011 << off;
            default: calc_be = 4'b1111;
        endcase
    endfunction

    // Stores replicate the datum across all lanes; byte enables pick the lane.
    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] rs2);
        case (size)
            2'b00:   calc_wdata = {4{rs2[7:0]}};
            2'b01:   calc_wdata = {2{rs2[15:0]}};
            default: calc_wdata = rs2;
        endcase
    endfunction

    // Pick the addressed byte/half out of the read word and extend it.
    function automatic logic [31:0] extract_load(input logic [2:0] op, input logic [1:0] off,
                                                 input logic [31:0] rword);
        logic [7:0]  b;
        logic [15:0] h;
        b = rword[{off, 3'b000} +: 8];
        h = off[1] ? rword[31:16] : rword[15:0];
        case (op)
            3'b000:  extract_load = {{24{b[7]}}, b};
            3'b100:  extract_load = {24'h00_0000, b};
            3'b001:  extract_load = {{16{h[15]}}, h};
            3'b101:  extract_load = {16'h0000, h};
            default: extract_load = rword;
        endcase
    endfunction

    // Decode the EX/MEM request and derive handshake/stall conditions.
    always_comb begin
        size_s       = EX_Mem_op[1:0];
        off_s        = EX_ALU_result[1:0];
        access_s     = EX_Mem_rd_en | EX_Mem_wr_en;
        is_load_s    = EX_Mem_rd_en & ~EX_Mem_wr_en;
        misaligned_s = is_misaligned(size_s, off_s);
        issue_s      = (state_q == ST_IDLE) & access_s & ~misaligned_s;
        done_s       = (state_q == ST_RESP) & dmem.DMem_rvalid;
        // A response arriving on the final allowed cycle still wins.
        timeout_s    = (state_q != ST_IDLE) & (tmo_cnt_q == TMO_LAST) & ~done_s;
        stall_s      = issue_s
                     | ((state_q == ST_REQ) & ~timeout_s)
                     | ((state_q == ST_RESP) & ~dmem.DMem_rvalid & ~timeout_s);
    end

    assign MEM_Stall       = stall_s;
    assign dmem.DMem_req   = issue_s | ((state_q == ST_REQ) & ~timeout_s);
    assign dmem.DMem_we    = EX_Mem_wr_en;
    assign dmem.DMem_addr  = {EX_ALU_result[31:2], 2'b00};
    assign dmem.DMem_be    = calc_be(size_s, off_s);
    assign dmem.DMem_wdata = calc_wdata(size_s, EX_Rs2_data);

    // Access FSM and timeout counter; the counter is zero whenever idle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tmo_cnt_q <= 8'd0;
                    if (issue_s) begin
                        state_q <= dmem.DMem_gnt ? ST_RESP : ST_REQ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    if (timeout_s) begin
                        state_q <= ST_IDLE;
                    end else if (dmem.DMem_gnt) begin
                        state_q <= ST_RESP;
                    end else begin
                        state_q <= ST_REQ;
                    end
                end
                ST_RESP: begin
                    tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    if (timeout_s || done_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    tmo_cnt_q <= 8'd0;
                end
            endcase
        end
    end

    // MEM/WB next value: bubble while stalled, otherwise the EX fields with
    // write-back suppressed for dropped or abandoned accesses.
    always_comb begin
        wb_wr_en_d = 1'b0;
        wb_rd_d    = 5'd0;
        wb_m2r_d   = 1'b0;
        wb_alu_d   = 32'd0;
        wb_rdata_d = 32'd0;
        wb_mis_d   = 1'b0;
        wb_berr_d  = 1'b0;
        if (!stall_s) begin
            wb_wr_en_d = EX_RegFile_wr_en;
            wb_rd_d    = EX_Rd_addr;
            wb_m2r_d   = EX_MemToReg;
            wb_alu_d   = EX_ALU_result;
            if ((state_q == ST_IDLE) && access_s && misaligned_s) begin
                wb_wr_en_d = 1'b0;
                wb_mis_d   = 1'b1;
            end else if (timeout_s) begin
                wb_wr_en_d = 1'b0;
                wb_berr_d  = 1'b1;
            end else if (done_s && is_load_s) begin
                wb_rdata_d = extract_load(EX_Mem_op, off_s, dmem.DMem_rdata);
            end else begin
                wb_rdata_d = 32'd0;
            end
        end else begin
            wb_wr_en_d = 1'b0;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wb_wr_en_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_m2r_q   <= 1'b0;
            wb_alu_q   <= 32'd0;
            wb_rdata_q <= 32'd0;
            wb_mis_q   <= 1'b0;
            wb_berr_q  <= 1'b0;
        end else begin
            wb_wr_en_q <= wb_wr_en_d;
            wb_rd_q    <= wb_rd_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_alu_q   <= wb_alu_d;
            wb_rdata_q <= wb_rdata_d;
            wb_mis_q   <= wb_mis_d;
            wb_berr_q  <= wb_berr_d;
        end
    end

    assign MEM_RegFile_wr_en = wb_wr_en_q;
    assign MEM_Rd_addr       = wb_rd_q;
    assign MEM_MemToReg      = wb_m2r_q;
    assign MEM_ALU_result    = wb_alu_q;
    assign MEM_Read_data     = wb_rdata_q;
    assign MEM_Misaligned    = wb_mis_q;
    assign MEM_Bus_error     = wb_berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage. The bench plays the memory slave, predicts
// every transaction from the access rules (size, alignment, grant/response
// delays, timeout) and checks all outputs on every cycle.
module tb_mem_stage;

    logic        Clk;
    logic        Reset_n;
    logic        EX_Mem_wr_en, EX_Mem_rd_en, EX_MemToReg, EX_RegFile_wr_en;
    logic [2:0]  EX_Mem_op;
    logic [31:0] EX_ALU_result, EX_Rs2_data;
    logic [4:0]  EX_Rd_addr;
    logic        MEM_Stall, MEM_RegFile_wr_en, MEM_MemToReg, MEM_Misaligned, MEM_Bus_error;
    logic [4:0]  MEM_Rd_addr;
    logic [31:0] MEM_ALU_result, MEM_Read_data;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT_CYCLES(255)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .EX_Mem_wr_en(EX_Mem_wr_en), .EX_Mem_rd_en(EX_Mem_rd_en), .EX_Mem_op(EX_Mem_op),
        .EX_ALU_result(EX_ALU_result), .EX_Rs2_data(EX_Rs2_data), .EX_MemToReg(EX_MemToReg),
        .EX_RegFile_wr_en(EX_RegFile_wr_en), .EX_Rd_addr(EX_Rd_addr),
        .MEM_Stall(MEM_Stall), .dmem(bus),
        .MEM_RegFile_wr_en(MEM_RegFile_wr_en), .MEM_Rd_addr(MEM_Rd_addr),
        .MEM_MemToReg(MEM_MemToReg), .MEM_ALU_result(MEM_ALU_result),
        .MEM_Read_data(MEM_Read_data), .MEM_Misaligned(MEM_Misaligned),
        .MEM_Bus_error(MEM_Bus_error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        wr_en;
        logic [4:0]  rd;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        mis;
        logic        berr;
    } wb_t;

    wb_t         exp_wb;
    logic        exp_stall, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    bit          chk_on;
    int          total, bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int sz_bytes(input logic [2:0] op);
        if (op[1:0] == 2'b00) return 1;
        if (op[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_mis(input logic [2:0] op, input logic [31:0] a);
        return (a % sz_bytes(op)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] a);
        int lanes;
        lanes = ((1 << sz_bytes(op)) - 1) << (a % 4);
        return lanes[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] rs2);
        if (sz_bytes(op) == 1) return {24'd0, rs2[7:0]} * 32'h0101_0101;
        if (sz_bytes(op) == 2) return {16'd0, rs2[15:0]} * 32'h0001_0001;
        return rs2;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w);
        longint span, v;
        span = longint'(64'd1) << (8 * sz_bytes(op));
        v = longint'(w >> (8 * (a % 4))) % span;
        if (!op[2] && sz_bytes(op) < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        if (chk_on) begin
            chk("stall", MEM_Stall, exp_stall);
            chk("req", bus.DMem_req, exp_req);
            if (exp_req) begin
                chk("we", bus.DMem_we, exp_we);
                chk("addr", bus.DMem_addr, exp_addr);
                chk("be", bus.DMem_be, exp_be);
                chk("wdata", bus.DMem_wdata, exp_wdata);
            end
            chk("wb_wr_en", MEM_RegFile_wr_en, exp_wb.wr_en);
            chk("wb_rd", MEM_Rd_addr, exp_wb.rd);
            chk("wb_m2r", MEM_MemToReg, exp_wb.m2r);
            chk("wb_alu", MEM_ALU_result, exp_wb.alu);
            chk("wb_rdata", MEM_Read_data, exp_wb.rdata);
            chk("wb_mis", MEM_Misaligned, exp_wb.mis);
            chk("wb_berr", MEM_Bus_error, exp_wb.berr);
        end
    end

    // One instruction through MEM: g = grant delay, r = response delay after grant.
    task automatic do_instr(input logic rd_i, input logic wr_i, input logic [2:0] op,
                            input logic [31:0] alu, input logic [31:0] rs2, input logic m2r,
                            input logic rfw, input logic [4:0] rdd, input int g, input int r,
                            input logic [31:0] mword);
        bit  acc, mis, tmo;
        int  n_cyc, req_last;
        wb_t fin;
        acc = rd_i | wr_i;
        mis = acc && m_mis(op, alu);
        tmo = acc && !mis && (g + r > 255);
        if (!acc || mis) n_cyc = 1;
        else if (tmo)    n_cyc = 256;
        else             n_cyc = g + r + 1;
        req_last = (acc && !mis) ? ((g < 254) ? g : 254) : -1;
        fin.wr_en = rfw && !mis && !tmo;
        fin.rd    = rdd;
        fin.m2r   = m2r;
        fin.alu   = alu;
        fin.rdata = (acc && !mis && !tmo && rd_i) ? m_load(op, alu, mword) : 32'd0;
        fin.mis   = mis;
        fin.berr  = tmo;
        EX_Mem_rd_en = rd_i; EX_Mem_wr_en = wr_i; EX_Mem_op = op; EX_ALU_result = alu;
        EX_Rs2_data = rs2; EX_MemToReg = m2r; EX_RegFile_wr_en = rfw; EX_Rd_addr = rdd;
        exp_we = wr_i;
        exp_addr = alu - (alu % 4);
        exp_be = m_be(op, alu);
        exp_wdata = m_wdata(op, rs2);
        for (int c = 0; c < n_cyc; c++) begin
            bus.DMem_gnt = acc && !mis && (c == g) && (c <= 254);
            if (acc && !mis && c == g + r) begin
                bus.DMem_rvalid = 1'b1;
                bus.DMem_rdata  = mword;
            end else if (c <= g || !acc || mis) begin
                bus.DMem_rvalid = 1'($urandom_range(0, 1));
                bus.DMem_rdata  = $urandom;
            end else begin
                bus.DMem_rvalid = 1'b0;
                bus.DMem_rdata  = $urandom;
            end
            exp_stall = (c < n_cyc - 1);
            exp_req   = (c <= req_last);
            @(posedge Clk);
            #1;
            exp_wb = (c == n_cyc - 1) ? fin : '0;
        end
        bus.DMem_gnt = 1'b0;
        bus.DMem_rvalid = 1'b0;
    endtask

    initial begin
        logic [2:0] ld_ops [5];
        total = 0; bad = 0; chk_on = 1'b0;
        ld_ops[0] = 3'b000; ld_ops[1] = 3'b001; ld_ops[2] = 3'b010;
        ld_ops[3] = 3'b100; ld_ops[4] = 3'b101;
        exp_wb = '0; exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
        exp_addr = 32'd0; exp_be = 4'd0; exp_wdata = 32'd0;
        Reset_n = 1'b0;
        EX_Mem_wr_en = 1'b0; EX_Mem_rd_en = 1'b0; EX_Mem_op = 3'd0; EX_ALU_result = 32'd0;
        EX_Rs2_data = 32'd0; EX_MemToReg = 1'b0; EX_RegFile_wr_en = 1'b0; EX_Rd_addr = 5'd0;
        bus.DMem_gnt = 1'b0; bus.DMem_rvalid = 1'b0; bus.DMem_rdata = 32'd0;

        // Reset state
        #2;
        chk("rst_req", bus.DMem_req, 32'd0);
        chk("rst_stall", MEM_Stall, 32'd0);
        chk("rst_wr_en", MEM_RegFile_wr_en, 32'd0);
        chk("rst_alu", MEM_ALU_result, 32'd0);
        chk("rst_rdata", MEM_Read_data, 32'd0);
        chk("rst_flags", {MEM_Misaligned, MEM_Bus_error, MEM_MemToReg}, 32'd0);
        @(negedge Clk);
        #1;
        Reset_n = 1'b1;
        chk_on = 1'b1;

        // Pin the model on hand-computed values
        chk("pin_lb", m_load(3'b000, 32'h103, 32'h80FF_00AA), 32'hFFFF_FF80);
        chk("pin_lhu", m_load(3'b101, 32'h102, 32'h8001_7FFF), 32'h0000_8001);
        chk("pin_lh", m_load(3'b001, 32'h102, 32'h8001_7FFF), 32'hFFFF_8001);
        chk("pin_sb_be", m_be(3'b000, 32'h201), 32'h2);
        chk("pin_sb_wd", m_wdata(3'b000, 32'hDEAD_BEEF), 32'hEFEF_EFEF);
        chk("pin_sh_be", m_be(3'b001, 32'h202), 32'hC);
        chk("pin_sw_mis", m_mis(3'b010, 32'h302), 32'd1);

        // Directed cases
        do_instr(0, 0, 3'b000, 32'h1234, 32'h0, 0, 1, 5'd5, 0, 1, 32'h0);
        do_instr(1, 0, 3'b000, 32'h103, 32'h0, 1, 1, 5'd6, 0, 1, 32'h80FF_00AA);
        do_instr(1, 0, 3'b101, 32'h102, 32'h0, 1, 1, 5'd7, 0, 2, 32'h8001_7FFF);
        do_instr(1, 0, 3'b001, 32'h102, 32'h0, 1, 1, 5'd8, 1, 1, 32'h8001_7FFF);
        do_instr(0, 1, 3'b000, 32'h201, 32'hDEAD_BEEF, 0, 0, 5'd0, 3, 1, 32'h0);
        do_instr(0, 1, 3'b010, 32'h302, 32'h1111_2222, 0, 1, 5'd9, 0, 1, 32'h0);
        do_instr(1, 0, 3'b001, 32'h401, 32'h0, 1, 1, 5'd10, 0, 1, 32'h0);
        do_instr(1, 0, 3'b010, 32'h400, 32'h0, 1, 1, 5'd11, 0, 1000, 32'h0);
        do_instr(1, 0, 3'b010, 32'h404, 32'h0, 1, 1, 5'd12, 1000, 1, 32'h0);
        do_instr(1, 0, 3'b010, 32'h408, 32'h0, 1, 1, 5'd13, 0, 255, 32'hCAFE_F00D);
        do_instr(1, 0, 3'b010, 32'h40C, 32'h0, 1, 1, 5'd14, 1, 255, 32'hCAFE_F00D);

        // Reset while waiting for a response
        EX_Mem_rd_en = 1'b1; EX_Mem_wr_en = 1'b0; EX_Mem_op = 3'b010; EX_ALU_result = 32'h500;
        EX_RegFile_wr_en = 1'b1; EX_Rd_addr = 5'd7; EX_MemToReg = 1'b1;
        exp_we = 1'b0; exp_addr = 32'h500; exp_be = 4'hF; exp_wdata = EX_Rs2_data;
        bus.DMem_gnt = 1'b1; exp_stall = 1'b1; exp_req = 1'b1;
        @(posedge Clk); #1; exp_wb = '0;
        bus.DMem_gnt = 1'b0; exp_req = 1'b0;
        @(posedge Clk); #1; exp_wb = '0;
        chk_on = 1'b0;
        #1;
        Reset_n = 1'b0;
        EX_Mem_rd_en = 1'b0; EX_RegFile_wr_en = 1'b0; EX_Rd_addr = 5'd0;
        EX_MemToReg = 1'b0; EX_ALU_result = 32'd0;
        #1;
        chk("midrst_req", bus.DMem_req, 32'd0);
        chk("midrst_stall", MEM_Stall, 32'd0);
        chk("midrst_wr_en", MEM_RegFile_wr_en, 32'd0);
        @(posedge Clk);
        bus.DMem_rvalid = 1'b1;
        @(negedge Clk);
        #1;
        Reset_n = 1'b1;
        exp_stall = 1'b0; exp_req = 1'b0; exp_wb = '0;
        chk_on = 1'b1;
        @(posedge Clk); #1; exp_wb = '0;
        bus.DMem_rvalid = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            int          kind, g, r;
            logic [2:0]  op;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            op = (kind == 2) ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 4)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a - (a % sz_bytes(op));
            g = $urandom_range(0, 3);
            r = $urandom_range(1, 3);
            do_instr(kind == 1, kind == 2, op, a, $urandom, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), g, r, $urandom);
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
